// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants, counter-action encoding and the countdown-width helper for the load-use scoreboard.
// Optional build macro for the whole slice: HAZARD_SCOREBOARD_PERF_EN (stall cycle counter).
package hazard_scoreboard_pkg;

   localparam int HS_REG_ADDR_W           = 5;
   localparam int HS_NUM_REGS             = 32;
   localparam int HS_ZERO_REG             = 31;
   localparam int HS_DEFAULT_LOAD_LATENCY = 1;

   // What a single register counter does on the next clock edge.
   typedef enum logic [1:0] {
      CNT_HOLD  = 2'd0,
      CNT_DEC   = 2'd1,
      CNT_LOAD  = 2'd2,
      CNT_CLEAR = 2'd3
   } cnt_action_e;

   // Bits needed to hold a countdown starting at the load latency.
   function automatic int hsCntWidth(input int lat);
      return (lat < 1) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/hazard_reg_counter.sv
// Pending-load countdown for one architectural register; a new writer overrides any load in flight.
// Optional build macro for the slice: HAZARD_SCOREBOARD_PERF_EN (not used in this file).
module hazard_reg_counter
   import hazard_scoreboard_pkg::*;
#(
   parameter int LOAD_LATENCY = HS_DEFAULT_LOAD_LATENCY,
   parameter int CNT_W        = hsCntWidth(LOAD_LATENCY)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_set,
   input  logic             i_load,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_pending
);

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOAD_LATENCY);

   cnt_action_e      w_action;
   logic [CNT_W-1:0] r_cnt;

   // An issuing writer takes priority over the running countdown, so a same-cycle set beats the decrement.
   always_comb begin
      w_action = CNT_HOLD;
      if (i_set) begin
         w_action = i_load ? CNT_LOAD : CNT_CLEAR;
      end else if (r_cnt != '0) begin
         w_action = CNT_DEC;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else begin
         case (w_action)
            CNT_LOAD:  r_cnt <= LOAD_VAL;
            CNT_CLEAR: r_cnt <= '0;
            CNT_DEC:   r_cnt <= r_cnt - 1'b1;
            default:   r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_cnt     = r_cnt;
   assign o_pending = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage load-use scoreboard: per-register load countdowns drive the PC/IF_ID hold and ID_EX bubble.
// Optional build macro: HAZARD_SCOREBOARD_PERF_EN adds a saturating 32-bit stall_count output.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int REG_ADDR_W   = HS_REG_ADDR_W,
   parameter int NUM_REGS     = HS_NUM_REGS,
   parameter int LOAD_LATENCY = HS_DEFAULT_LOAD_LATENCY,
   parameter int ZERO_REG     = HS_ZERO_REG
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rn,
   input  logic [REG_ADDR_W-1:0] id_rm,
   input  logic                  id_uses_rn,
   input  logic                  id_uses_rm,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  flush,
   output logic                  stall,
`ifdef HAZARD_SCOREBOARD_PERF_EN
   output logic [31:0]           stall_count,
`endif
   output logic [NUM_REGS-1:0]   pending_mask
);

   localparam int                    CNT_W    = hsCntWidth(LOAD_LATENCY);
   localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

   logic [CNT_W-1:0]    w_cnt [NUM_REGS];
   logic [NUM_REGS-1:0] w_set;
   logic [NUM_REGS-1:0] w_pending;
   logic                w_hitRn;
   logic                w_hitRm;
   logic                w_stall;
   logic                w_issue;

   // A source only hazards when it is really read, is not XZR, and its producer load is still counting down.
   assign w_hitRn = id_uses_rn && (id_rn != ZERO_IDX) && (w_cnt[id_rn] != '0);
   assign w_hitRm = id_uses_rm && (id_rm != ZERO_IDX) && (w_cnt[id_rm] != '0);
   assign w_stall = id_valid && !flush && (w_hitRn || w_hitRm);
   assign w_issue = id_valid && !w_stall && !flush;

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [REG_ADDR_W-1:0] IDX = REG_ADDR_W'(gi);

      if (gi == ZERO_REG) begin : g_zero
         assign w_set[gi] = 1'b0;
      end else begin : g_arch
         assign w_set[gi] = w_issue && id_reg_write && (id_rd == IDX);
      end

      hazard_reg_counter #(
         .LOAD_LATENCY (LOAD_LATENCY),
         .CNT_W        (CNT_W)
      ) u_cnt (
         .clk       (clk),
         .reset     (reset),
         .i_set     (w_set[gi]),
         .i_load    (id_mem_read),
         .o_cnt     (w_cnt[gi]),
         .o_pending (w_pending[gi])
      );
   end

   assign stall        = w_stall;
   assign pending_mask = w_pending;

`ifdef HAZARD_SCOREBOARD_PERF_EN
   logic [31:0] r_stallCount;

   // Counts bubble cycles for profiling; pins at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stallCount <= '0;
      end else if (w_stall && (r_stallCount != 32'hFFFF_FFFF)) begin
         r_stallCount <= r_stallCount + 32'd1;
      end
   end

   assign stall_count = r_stallCount;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard with one LOAD_LATENCY=1 and one LOAD_LATENCY=3 instance.
// Optional build macro: HAZARD_SCOREBOARD_PERF_EN enables the stall_count checks.
module tb_hazard_scoreboard;

   logic        clock;
   logic        reset;
   logic        idValid;
   logic [4:0]  idRn;
   logic [4:0]  idRm;
   logic        idUsesRn;
   logic        idUsesRm;
   logic [4:0]  idRd;
   logic        idRegWrite;
   logic        idMemRead;
   logic        flush;
   logic        stallL1;
   logic        stallL3;
   logic [31:0] maskL1;
   logic [31:0] maskL3;
`ifdef HAZARD_SCOREBOARD_PERF_EN
   logic [31:0] stallCountL1;
   logic [31:0] stallCountL3;
`endif

   int total = 0;
   int bad   = 0;

   hazard_scoreboard #(.LOAD_LATENCY(1)) dutL1 (
      .clk          (clock),
      .reset        (reset),
      .id_valid     (idValid),
      .id_rn        (idRn),
      .id_rm        (idRm),
      .id_uses_rn   (idUsesRn),
      .id_uses_rm   (idUsesRm),
      .id_rd        (idRd),
      .id_reg_write (idRegWrite),
      .id_mem_read  (idMemRead),
      .flush        (flush),
      .stall        (stallL1),
`ifdef HAZARD_SCOREBOARD_PERF_EN
      .stall_count  (stallCountL1),
`endif
      .pending_mask (maskL1)
   );

   hazard_scoreboard #(.LOAD_LATENCY(3)) dutL3 (
      .clk          (clock),
      .reset        (reset),
      .id_valid     (idValid),
      .id_rn        (idRn),
      .id_rm        (idRm),
      .id_uses_rn   (idUsesRn),
      .id_uses_rm   (idUsesRm),
      .id_rd        (idRd),
      .id_reg_write (idRegWrite),
      .id_mem_read  (idMemRead),
      .flush        (flush),
      .stall        (stallL3),
`ifdef HAZARD_SCOREBOARD_PERF_EN
      .stall_count  (stallCountL3),
`endif
      .pending_mask (maskL3)
   );

   // Free-running 10-unit clock; inputs change on the falling edge, state moves on the rising edge.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Places one instruction in ID.
   task automatic applyStimulus(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                                input logic urn, input logic urm, input logic [4:0] rd,
                                input logic rw, input logic mr, input logic fl);
      idValid    = v;
      idRn       = rn;
      idRm       = rm;
      idUsesRn   = urn;
      idUsesRm   = urm;
      idRd       = rd;
      idRegWrite = rw;
      idMemRead  = mr;
      flush      = fl;
   endtask

   task automatic applyIdle();
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Pulses reset across one full cycle with ID idle, leaving reset low at a falling edge.
   task automatic doReset();
      @(negedge clock);
      applyIdle();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      applyIdle();
      reset = 1'b1;
      #2;
      checkOutput("rst_stall_l1", {31'd0, stallL1}, 32'd0);
      checkOutput("rst_mask_l1", maskL1, 32'd0);
      checkOutput("rst_stall_l3", {31'd0, stallL3}, 32'd0);
      checkOutput("rst_mask_l3", maskL3, 32'd0);
      @(negedge clock);
      reset = 1'b0;
`ifdef HAZARD_SCOREBOARD_PERF_EN
      #1;
      checkOutput("rst_stall_count", stallCountL1, 32'd0);
`endif

      // L=1: LDUR x1,[x2] then ADD x2,x1,x3 stalls exactly one cycle.
      @(negedge clock);
      applyStimulus(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0);
      #1 checkOutput("l1_ldur_stall", {31'd0, stallL1}, 32'd0);
      @(negedge clock);
      applyStimulus(1'b1, 5'd1, 5'd3, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
      #1 checkOutput("l1_add_stall_c1", {31'd0, stallL1}, 32'd1);
      checkOutput("l1_mask_c1", maskL1, 32'h0000_0002);
      @(negedge clock);
      #1 checkOutput("l1_add_stall_c2", {31'd0, stallL1}, 32'd0);
      checkOutput("l1_mask_c2", maskL1, 32'd0);
      @(negedge clock);
      applyIdle();
      #1 checkOutput("l1_mask_after", maskL1, 32'd0);
`ifdef HAZARD_SCOREBOARD_PERF_EN
      checkOutput("l1_stall_count", stallCountL1, 32'd1);
`endif

      // L=3: LDUR x5 then SUB x10,x6,x5 stalls three cycles.
      doReset();
      @(negedge clock);
      applyStimulus(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      #1 checkOutput("l3_ldur_stall", {31'd0, stallL3}, 32'd0);
      @(negedge clock);
      applyStimulus(1'b1, 5'd6, 5'd5, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
      #1 checkOutput("l3_mask_first", maskL3, 32'h0000_0020);
      for (int k = 0; k < 3; k++) begin
         if (k != 0) @(negedge clock);
         #1 checkOutput($sformatf("l3_sub_stall_c%0d", k), {31'd0, stallL3}, 32'd1);
      end
      @(negedge clock);
      #1 checkOutput("l3_sub_release", {31'd0, stallL3}, 32'd0);
      checkOutput("l3_mask_release", maskL3, 32'd0);

      // L=3: independent ADD x6,x7,x8 after the load never stalls.
      doReset();
      @(negedge clock);
      applyStimulus(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      @(negedge clock);
      applyStimulus(1'b1, 5'd7, 5'd8, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
      #1 checkOutput("l3_indep_stall", {31'd0, stallL3}, 32'd0);
      @(negedge clock);
      applyIdle();
      #1 checkOutput("l3_indep_mask", maskL3, 32'h0000_0020);

      // LDUR x31 then ADD reading x31 never hazards.
      doReset();
      @(negedge clock);
      applyStimulus(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0);
      #1 checkOutput("xzr_ldur_mask", maskL3, 32'd0);
      @(negedge clock);
      applyStimulus(1'b1, 5'd31, 5'd31, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
      #1 checkOutput("xzr_add_stall", {31'd0, stallL3}, 32'd0);
      checkOutput("xzr_add_mask", maskL3, 32'd0);

      // L=3: LDUR x4, ADD x4,x9,x9 overwrites, then ORR reading x4 is free.
      doReset();
      @(negedge clock);
      applyStimulus(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
      @(negedge clock);
      applyStimulus(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
      #1 checkOutput("waw_add_stall", {31'd0, stallL3}, 32'd0);
      checkOutput("waw_add_mask", maskL3, 32'h0000_0010);
      @(negedge clock);
      applyStimulus(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
      #1 checkOutput("waw_orr_stall", {31'd0, stallL3}, 32'd0);
      checkOutput("waw_orr_mask", maskL3, 32'd0);

      // L=3: flushed dependent and flushed load leave the scoreboard alone.
      doReset();
      @(negedge clock);
      applyStimulus(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      @(negedge clock);
      applyStimulus(1'b1, 5'd6, 5'd5, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1);
      #1 checkOutput("flush_dep_stall", {31'd0, stallL3}, 32'd0);
      @(negedge clock);
      applyStimulus(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);
      #1 checkOutput("flush_dep_mask", maskL3, 32'h0000_0020);
      checkOutput("flush_ld_stall", {31'd0, stallL3}, 32'd0);
      @(negedge clock);
      applyIdle();
      #1 checkOutput("flush_ld_mask", maskL3, 32'h0000_0020);

      // L=3: reset mid-stall with cnt[3]=2 clears everything at once.
      doReset();
      @(negedge clock);
      applyStimulus(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
      @(negedge clock);
      applyStimulus(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      #1 checkOutput("mid_pre_stall", {31'd0, stallL3}, 32'd1);
      checkOutput("mid_pre_mask", maskL3, 32'h0000_0008);
      reset = 1'b1;
      #1 checkOutput("mid_rst_stall", {31'd0, stallL3}, 32'd0);
      checkOutput("mid_rst_mask", maskL3, 32'd0);
`ifdef HAZARD_SCOREBOARD_PERF_EN
      checkOutput("mid_rst_count", stallCountL3, 32'd0);
`endif
      @(negedge clock);
      reset = 1'b0;
      #1 checkOutput("mid_post_stall", {31'd0, stallL3}, 32'd0);
      @(negedge clock);
      applyIdle();
      #1 checkOutput("mid_post_mask", maskL3, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle load-use detector in the ARMv8 pipeline decode stage.
- Keeps a per-register pending-load countdown, so the memory latency can be configured.
- Raises stall while any source register of the ID-stage instruction still waits on an in-flight load.
- Handles the zero register, per-source use enables, flush and same-register overwrite; the stall output drives the PC/IF_ID write-enables and the ID_EX bubble mux.

Parameters:
- REG_ADDR_W, 5, width of register specifiers.
- NUM_REGS, 32, number of architectural registers tracked (2**REG_ADDR_W).
- LOAD_LATENCY, 1, cycles after a load leaves ID before its result is forwardable to ID (1 = classic single bubble); legal range 1..7.
- ZERO_REG, 31, register index that never creates a hazard (XZR).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- id_valid  input  1  ID stage holds a real instruction.
- id_rn  input  REG_ADDR_W  first source register.
- id_rm  input  REG_ADDR_W  second source register.
- id_uses_rn  input  1  instruction reads rn.
- id_uses_rm  input  1  instruction reads rm.
- id_rd  input  REG_ADDR_W  destination register.
- id_reg_write  input  1  instruction writes rd.
- id_mem_read  input  1  instruction is a load.
- flush  input  1  branch-taken squash of the ID instruction this cycle.
- stall  output  1  hold PC and IF_ID, insert a bubble into ID_EX.
- pending_mask  output  NUM_REGS  bit i = register i has a nonzero countdown.

Behaviour:
- State: cnt[i], i = 0..NUM_REGS-1, each $clog2(LOAD_LATENCY+1) bits wide.
- Reset: all cnt = 0 asynchronously. stall = 0 and pending_mask = 0 while reset is high and in the first cycle after it.
- stall is combinational from the current cnt values and the ID inputs:
  - stall = id_valid & !flush & (hit_rn | hit_rm).
  - hit_rn = id_uses_rn & (id_rn != ZERO_REG) & (cnt[id_rn] != 0); hit_rm is the same using rm.
  - rn == rm is a single hazard and needs no special case.
- issue = id_valid & !stall & !flush. A stalled or flushed instruction never updates the scoreboard.
- Per clock, for each i, in priority order:
  - if issue & id_reg_write & (id_rd == i) & (i != ZERO_REG): cnt[i] <= id_mem_read ? LOAD_LATENCY : 0. The newer writer overrides the pending load (WAW), and forwarding supplies the newer value.
  - else if cnt[i] != 0: cnt[i] <= cnt[i] - 1.
  - else cnt[i] holds.
- Same-cycle decrement and set on the same register: the set wins.
- A load to ZERO_REG never sets a counter.
- Latency with LOAD_LATENCY = L:
  - a load issues at cycle t; a dependent instruction in ID at t+1 stalls for exactly L cycles and issues at t+1+L.
  - an independent instruction is never stalled.
- flush does not clear existing counters; loads already past ID still complete.
- Counters saturate at 0; there is no wrap-around.
- pending_mask[i] = (cnt[i] != 0), registered view, no ID dependency.
- Reset asserted mid-operation clears all counters immediately; stall drops in the same cycle.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_PERF_EN.
- Defined:
  - adds output stall_count (32 bits), cleared on reset.
  - increments in every cycle with stall = 1; saturates at 32'hFFFF_FFFF.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package: REG_ADDR_W, NUM_REGS, ZERO_REG, default LOAD_LATENCY, and the counter-width function.
- One natural sub-module, hazard_reg_counter: a single register's load/decrement counter, instantiated NUM_REGS times via generate.
- Hit compare and issue logic stay in the top module.

Test Plan:
- L=1: LDUR x1 then ADD x2,x1,x3 back-to-back → stall=1 for exactly one cycle, ADD issues next cycle; pending_mask[1] set for one cycle.
- L=3: LDUR x5 then SUB using rm=x5 → stall high for 3 consecutive cycles, then 0; an independent ADD x6,x7,x8 in place of SUB → stall never asserts.
- LDUR x31 then ADD using x31 → stall=0 and pending_mask=0 throughout.
- L=3: LDUR x4, then ADD x4,x9,x9 (independent, overwrites x4), then ORR using x4 → cnt[4] cleared by ADD, ORR not stalled.
- Dependent instruction in ID with flush=1 → stall=0, no counter set; a flushed load leaves pending_mask unchanged.
- Reset asserted while cnt[3]=2 and stall=1 → stall and pending_mask go to 0 asynchronously; with HAZARD_SCOREBOARD_PERF_EN, stall_count = 0 after reset and equals the number of stalled cycles after the first scenario (1).
